// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types, constants and width helpers for the clock divider manager
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_ALIGN  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int DIV_MIN = 1;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_w(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

    // Lock counter width: must hold LOCK_CYCLES itself so it can saturate.
    function automatic int lcnt_w(input int lock_cycles);
        return $clog2(lock_cycles + 1);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divide-by-D counter with registered enable and divided-clock decode
// Ports:
//   i_clk    rising-edge clock
//   i_rst    synchronous active-high reset (counter and outputs to 0)
//   i_clr    forces counter and outputs to 0 (entering ALIGN after a reconfig)
//   i_align  ALIGN state: counter held at 0, outputs preloaded for count 0
//   i_div    divide ratio, always >= 1
//   o_ce     1 while count == D-1
//   o_clk    1 while count < D/2
module clk_div_chan #(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_align,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_ce,
    output logic             o_clk
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_ce;
    logic             r_clk;
    logic [DIV_W-1:0] w_cnt_nx;

    // Outputs decode the count the counter is about to hold, so they line
    // up with r_cnt while remaining pure flops.
    always_comb begin
        w_cnt_nx = r_cnt + DIV_W'(1);
        if (i_align || (r_cnt >= i_div - DIV_W'(1))) begin
            w_cnt_nx = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
            r_ce  <= 1'b0;
            r_clk <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nx;
            r_ce  <= (w_cnt_nx == i_div - DIV_W'(1));
            r_clk <= (w_cnt_nx < (i_div >> 1));
        end
    end

    assign o_ce  = r_ce;
    assign o_clk = r_clk;

endmodule

// File: rtl/clk_div_mgr.sv
// rtl/clk_div_mgr.sv - multi-channel phase-aligned clock divider with runtime config and lock
// Ports:
//   i_clk_in1    rising-edge clock for all logic
//   i_reset      synchronous active-high reset
//   i_cfg_valid  config request, held by requester until accepted
//   o_cfg_ready  config accepted when valid & ready (only while locked)
//   i_cfg_ch     target channel; indices >= NCH complete the handshake but are ignored
//   i_cfg_div    new ratio, 0 treated as 1
//   o_ce_out     per-channel single-cycle enable, period D
//   o_clk_out    per-channel divided clock, period D
//   o_locked     all channels aligned and settled
module clk_div_mgr
    import clk_div_pkg::*;
#(
    parameter  int NCH         = 3,
    parameter  int DIV_W       = 8,
    parameter  int DIV_RST     = 2,
    parameter  int LOCK_CYCLES = 16,
    localparam int CH_W        = ch_w(NCH),
    localparam int LCNT_W      = lcnt_w(LOCK_CYCLES)
) (
    input  logic             i_clk_in1,
    input  logic             i_reset,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [CH_W-1:0]  i_cfg_ch,
    input  logic [DIV_W-1:0] i_cfg_div,
    output logic [NCH-1:0]   o_ce_out,
    output logic [NCH-1:0]   o_clk_out,
    output logic             o_locked
);

    localparam logic [DIV_W-1:0] DIV_RST_V =
        (DIV_RST < DIV_MIN) ? DIV_W'(DIV_MIN) : DIV_W'(DIV_RST);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LOCK_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX  = LCNT_W'(LOCK_CYCLES);

    state_t            r_state;
    logic [LCNT_W-1:0] r_lock_cnt;
    logic              r_locked;
    logic              r_cfg_ready;

    logic              w_ch_ok;
    logic              w_accept;
    logic              w_align;
    logic [DIV_W-1:0]  w_div_new;

    assign w_ch_ok   = (32'(i_cfg_ch) < 32'(NCH));
    // Ready is only ever high in LOCKED, so valid & ready is the handshake.
    assign w_accept  = i_cfg_valid && r_cfg_ready && w_ch_ok;
    assign w_align   = (r_state == ST_ALIGN);
    assign w_div_new = (i_cfg_div == '0) ? DIV_W'(DIV_MIN) : i_cfg_div;

    always_ff @(posedge i_clk_in1) begin
        if (i_reset) begin
            r_state     <= ST_ALIGN;
            r_lock_cnt  <= '0;
            r_locked    <= 1'b0;
            r_cfg_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_ALIGN: begin
                    r_state    <= ST_SETTLE;
                    r_lock_cnt <= '0;
                end
                ST_SETTLE: begin
                    if (r_lock_cnt == LCNT_LAST) begin
                        r_state     <= ST_LOCKED;
                        r_locked    <= 1'b1;
                        r_cfg_ready <= 1'b1;
                    end
                    if (r_lock_cnt != LCNT_MAX) begin
                        r_lock_cnt <= r_lock_cnt + LCNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // Any valid write re-phases every channel, not only the target.
                    if (w_accept) begin
                        r_state     <= ST_ALIGN;
                        r_locked    <= 1'b0;
                        r_cfg_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_ALIGN;
                    r_locked    <= 1'b0;
                    r_cfg_ready <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [DIV_W-1:0] r_div;

        always_ff @(posedge i_clk_in1) begin
            if (i_reset) begin
                r_div <= DIV_RST_V;
            end else if (w_accept && (32'(i_cfg_ch) == 32'(g))) begin
                r_div <= w_div_new;
            end
        end

        clk_div_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .i_clk   (i_clk_in1),
            .i_rst   (i_reset),
            .i_clr   (w_accept),
            .i_align (w_align),
            .i_div   (r_div),
            .o_ce    (o_ce_out[g]),
            .o_clk   (o_clk_out[g])
        );
    end

    assign o_locked    = r_locked;
    assign o_cfg_ready = r_cfg_ready;

endmodule

// File: tb/tb_clk_div_mgr.sv
// tb/tb_clk_div_mgr.sv - directed self-checking bench for clk_div_mgr
module tb_clk_div_mgr;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [2:0] ce_out;
    logic [2:0] clk_out;
    logic       locked;

    int n_vec = 0;
    int n_err = 0;
    int g_k   = 0;
    int m_div [3];

    always #5 clk = ~clk;

    clk_div_mgr dut (
        .i_clk_in1   (clk),
        .i_reset     (reset),
        .i_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .i_cfg_ch    (cfg_ch),
        .i_cfg_div   (cfg_div),
        .o_ce_out    (ce_out),
        .o_clk_out   (clk_out),
        .o_locked    (locked)
    );

    // k = edges since the edge that entered ALIGN; k=0 is the ALIGN cycle.
    function automatic logic [2:0] f_clk(input int k);
        logic [2:0] r = '0;
        for (int i = 0; i < 3; i++)
            if (k >= 1) r[i] = (((k - 1) % m_div[i]) < (m_div[i] / 2));
        return r;
    endfunction

    function automatic logic [2:0] f_ce(input int k);
        logic [2:0] r = '0;
        for (int i = 0; i < 3; i++)
            if (k >= 1) r[i] = (((k - 1) % m_div[i]) == (m_div[i] - 1));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        g_k++;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        m_div = '{2, 2, 2};
        tick(); tick(); g_k = 0;
        n_vec++; if (clk_out !== 3'b000) begin n_err++; $display("FAIL reset_clk got %b exp 000", clk_out); end
        n_vec++; if (ce_out !== 3'b000) begin n_err++; $display("FAIL reset_ce got %b exp 000", ce_out); end
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got %b exp 0", locked); end
        n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", cfg_ready); end
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_vec++; if (clk_out !== f_clk(g_k)) begin n_err++; $display("FAIL rel_clk k=%0d got %b exp %b", g_k, clk_out, f_clk(g_k)); end
            n_vec++; if (ce_out !== f_ce(g_k)) begin n_err++; $display("FAIL rel_ce k=%0d got %b exp %b", g_k, ce_out, f_ce(g_k)); end
            n_vec++; if (locked !== (g_k >= 17)) begin n_err++; $display("FAIL rel_locked k=%0d got %b", g_k, locked); end
            n_vec++; if (cfg_ready !== (g_k >= 17)) begin n_err++; $display("FAIL rel_ready k=%0d got %b", g_k, cfg_ready); end
        end
    endtask

    task automatic test_cfg(input logic [1:0] ch, input logic [7:0] div, input int mdl_div, input int n);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_div = div;
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL cfg_ready_pre ch=%0d got %b exp 1", ch, cfg_ready); end
        tick(); g_k = 0; cfg_valid = 1'b0;
        m_div[ch] = mdl_div;
        n_vec++; if ({clk_out, ce_out} !== 6'b0) begin n_err++; $display("FAIL cfg_align_out got %b exp 0", {clk_out, ce_out}); end
        n_vec++; if ({locked, cfg_ready} !== 2'b00) begin n_err++; $display("FAIL cfg_align_lock got %b exp 00", {locked, cfg_ready}); end
        for (int k = 1; k <= n; k++) begin
            tick();
            n_vec++; if (clk_out !== f_clk(g_k)) begin n_err++; $display("FAIL cfg_clk d=%0d k=%0d got %b exp %b", div, g_k, clk_out, f_clk(g_k)); end
            n_vec++; if (ce_out !== f_ce(g_k)) begin n_err++; $display("FAIL cfg_ce d=%0d k=%0d got %b exp %b", div, g_k, ce_out, f_ce(g_k)); end
            n_vec++; if (locked !== (g_k >= 17)) begin n_err++; $display("FAIL cfg_locked k=%0d got %b", g_k, locked); end
        end
    endtask

    task automatic test_out_of_range();
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7;
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL oor_ready_pre got %b exp 1", cfg_ready); end
        tick();
        cfg_valid = 1'b0;
        n_vec++; if ({locked, cfg_ready} !== 2'b11) begin n_err++; $display("FAIL oor_lock got %b exp 11", {locked, cfg_ready}); end
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            n_vec++; if (clk_out !== f_clk(g_k)) begin n_err++; $display("FAIL oor_clk k=%0d got %b exp %b", g_k, clk_out, f_clk(g_k)); end
            n_vec++; if (ce_out !== f_ce(g_k)) begin n_err++; $display("FAIL oor_ce k=%0d got %b exp %b", g_k, ce_out, f_ce(g_k)); end
            n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL oor_locked k=%0d got %b exp 1", g_k, locked); end
        end
    endtask

    task automatic test_settle_hold();
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3;
        tick(); g_k = 0; cfg_valid = 1'b0; m_div[2] = 3;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (g_k == 2) begin cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd4; end
            n_vec++; if (clk_out !== f_clk(g_k)) begin n_err++; $display("FAIL hold_clk k=%0d got %b exp %b", g_k, clk_out, f_clk(g_k)); end
            n_vec++; if (ce_out !== f_ce(g_k)) begin n_err++; $display("FAIL hold_ce k=%0d got %b exp %b", g_k, ce_out, f_ce(g_k)); end
            n_vec++; if (cfg_ready !== (g_k >= 17)) begin n_err++; $display("FAIL hold_ready k=%0d got %b", g_k, cfg_ready); end
        end
        tick(); g_k = 0; cfg_valid = 1'b0; m_div[2] = 4;
        n_vec++; if ({locked, cfg_ready, clk_out, ce_out} !== 8'b0) begin n_err++; $display("FAIL hold_accept got %b exp 0", {locked, cfg_ready, clk_out, ce_out}); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_vec++; if (clk_out !== f_clk(g_k)) begin n_err++; $display("FAIL hold_new_clk k=%0d got %b exp %b", g_k, clk_out, f_clk(g_k)); end
            n_vec++; if (ce_out !== f_ce(g_k)) begin n_err++; $display("FAIL hold_new_ce k=%0d got %b exp %b", g_k, ce_out, f_ce(g_k)); end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd9;
        tick(); g_k = 0;
        n_vec++; if ({locked, cfg_ready, clk_out, ce_out} !== 8'b0) begin n_err++; $display("FAIL rmid_out got %b exp 0", {locked, cfg_ready, clk_out, ce_out}); end
        reset = 1'b0; cfg_valid = 1'b0;
        m_div = '{2, 2, 2};
        for (int k = 1; k <= 18; k++) begin
            tick();
            n_vec++; if (clk_out !== f_clk(g_k)) begin n_err++; $display("FAIL rmid_clk k=%0d got %b exp %b", g_k, clk_out, f_clk(g_k)); end
            n_vec++; if (ce_out !== f_ce(g_k)) begin n_err++; $display("FAIL rmid_ce k=%0d got %b exp %b", g_k, ce_out, f_ce(g_k)); end
            n_vec++; if (locked !== (g_k >= 17)) begin n_err++; $display("FAIL rmid_locked k=%0d got %b", g_k, locked); end
        end
    endtask

    initial begin
        test_reset();
        test_cfg(2'd1, 8'd5, 5, 22);
        test_cfg(2'd0, 8'd0, 1, 18);
        test_cfg(2'd0, 8'd1, 1, 18);
        test_out_of_range();
        test_settle_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
